// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller with burst refill
module dcache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int LINE_NUM   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        mem_stall,
  output logic [31:0] bus_addr,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [LINE_NUM-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINE_NUM];
  logic [31:0]        data_q [LINE_NUM*LINE_WORDS];

  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx, miss_idx;
  logic [TAG_W-1:0] cpu_tag, miss_tag;
  logic             req, hit, last_word;
  logic             wr_hit, fill_wr, fill_done;
  logic             unused_bits;

  assign cpu_off   = cpu_addr[OFF_W+1:2];
  assign cpu_idx   = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign cpu_tag   = cpu_addr[31:32-TAG_W];
  assign miss_idx  = miss_addr_q[IDX_W+OFF_W+1:OFF_W+2];
  assign miss_tag  = miss_addr_q[31:32-TAG_W];
  assign unused_bits = ^{cpu_addr[1:0], miss_addr_q[OFF_W+1:0]};

  assign req       = cpu_ren | cpu_wen;
  assign hit       = req & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
  assign last_word = (word_cnt_q == OFF_W'(LINE_WORDS - 1));
  assign cpu_dout  = data_q[{cpu_idx, cpu_off}];

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    miss_addr_d = miss_addr_q;
    mem_stall   = 1'b1;
    bus_cs      = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_dout    = '0;
    wr_hit      = 1'b0;
    fill_wr     = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = req & ~hit;
        wr_hit    = cpu_wen & hit;
        if (req & ~hit) begin
          miss_addr_d = cpu_addr;
          state_d     = (valid_q[cpu_idx] & dirty_q[cpu_idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        // Victim address is rebuilt from the stored tag; the miss address only supplies the index
        bus_cs   = 1'b1;
        bus_we   = 1'b1;
        bus_addr = {tag_q[miss_idx], miss_idx, word_cnt_q, 2'b00};
        bus_dout = data_q[{miss_idx, word_cnt_q}];
        if (bus_ack) begin
          word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
          if (last_word) state_d = FILL;
        end
      end
      FILL: begin
        bus_cs   = 1'b1;
        bus_addr = {miss_tag, miss_idx, word_cnt_q, 2'b00};
        if (bus_ack) begin
          fill_wr    = 1'b1;
          fill_done  = last_word;
          word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_hit) dirty_q[cpu_idx] <= 1'b1;
      if (fill_done) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Data and tags carry no reset; validity alone guards them
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_hit) data_q[{cpu_idx, cpu_off}] <= cpu_din;
      else if (fill_wr) data_q[{miss_idx, word_cnt_q}] <= bus_din;
      if (fill_done) tag_q[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a line-level cache model
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_ren, cpu_wen, mem_stall;
  logic [31:0] bus_addr, bus_dout, bus_din;
  logic        bus_cs, bus_we, bus_ack;

  int vectors = 0;
  int miscompares = 0;

  dcache_ctrl #(.LINE_WORDS(4), .LINE_NUM(64)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .mem_stall(mem_stall),
    .bus_addr(bus_addr), .bus_cs(bus_cs), .bus_we(bus_we),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;

  // Bus environment: backing memory, transaction log, wait-state responder
  logic [31:0] bmem [logic [31:0]];
  txn_t        log_q [$];
  int          bus_wait = 0;
  bit          spurious = 1'b0;
  int          stable_err = 0;

  // Cache model: what each line should hold from the CPU's point of view
  bit          mc_valid [64];
  bit          mc_dirty [64];
  logic [21:0] mc_tag   [64];
  logic [31:0] mc_data  [64][4];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  initial begin
    int          wcnt;
    logic [31:0] cap_addr, cap_dout;
    logic        cap_we;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_din = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_din = $urandom;
      if (bus_cs) begin
        if (wcnt == 0) begin
          cap_addr = bus_addr; cap_we = bus_we; cap_dout = bus_dout;
        end else if (bus_addr !== cap_addr || bus_we !== cap_we || (cap_we && bus_dout !== cap_dout)) begin
          stable_err++;
        end
        if (wcnt >= bus_wait) begin
          bus_ack = 1'b1;
          wcnt = 0;
          if (bus_we) bmem[bus_addr] = bus_dout;
          else bus_din = mem_rd(bus_addr);
          log_q.push_back('{bus_addr, bus_we, bus_we ? bus_dout : bus_din});
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (spurious && $urandom_range(0, 3) == 0) bus_ack = 1'b1;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mc_valid[i] = 1'b0;
      mc_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] din, input string nm);
    int          idx, off, exp_stall, base, stalls, nexp;
    logic [21:0] tg;
    logic [31:0] a, exp_dout, got;
    txn_t        exp_q [$];
    bit          done;
    idx = int'(addr[9:4]);
    off = int'(addr[3:2]);
    tg  = addr[31:10];
    exp_stall = 0;
    if (!(mc_valid[idx] && mc_tag[idx] == tg)) begin
      if (mc_valid[idx] && mc_dirty[idx])
        for (int w = 0; w < 4; w++)
          exp_q.push_back('{{mc_tag[idx], addr[9:4], 4'b0000} + 32'(w * 4), 1'b1, mc_data[idx][w]});
      for (int w = 0; w < 4; w++) begin
        a = {tg, addr[9:4], 4'b0000} + 32'(w * 4);
        exp_q.push_back('{a, 1'b0, mem_rd(a)});
        mc_data[idx][w] = mem_rd(a);
      end
      mc_valid[idx] = 1'b1;
      mc_dirty[idx] = 1'b0;
      mc_tag[idx]   = tg;
      exp_stall = 1 + exp_q.size() * (bus_wait + 1);
    end
    if (wen) begin
      mc_data[idx][off] = din;
      mc_dirty[idx] = 1'b1;
    end
    exp_dout = mc_data[idx][off];

    base = log_q.size();
    cpu_addr = addr; cpu_din = din; cpu_ren = ren; cpu_wen = wen;
    stalls = 0; done = 1'b0; got = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else begin
        got = cpu_dout;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    cpu_ren = 1'b0; cpu_wen = 1'b0;

    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s completion: stall never dropped within budget, required release", nm);
    end
    vectors++;
    if (stalls != exp_stall) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, exp_stall);
    end
    vectors++;
    nexp = exp_q.size();
    if (log_q.size() - base != nexp) begin
      miscompares++;
      $display("FAIL %s bus_words: got %0d required %0d", nm, log_q.size() - base, nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        vectors++;
        if (log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].we !== exp_q[i].we ||
            (exp_q[i].we && log_q[base+i].data !== exp_q[i].data)) begin
          miscompares++;
          $display("FAIL %s bus_word%0d: got addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                   nm, i, log_q[base+i].addr, log_q[base+i].we, log_q[base+i].data,
                   exp_q[i].addr, exp_q[i].we, exp_q[i].data);
        end
      end
    end
    if (ren && !wen) begin
      vectors++;
      if (got !== exp_dout) begin
        miscompares++;
        $display("FAIL %s cpu_dout: got %h required %h", nm, got, exp_dout);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    vectors++;
    if (mem_stall !== 1'b0 || bus_cs !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_dout !== 32'h0) begin
      miscompares++;
      $display("FAIL %s: got stall=%b cs=%b we=%b addr=%h dout=%h required all zero",
               nm, mem_stall, bus_cs, bus_we, bus_addr, bus_dout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    @(posedge clk); #1;
  endtask

  task automatic test_read_fill();
    bmem[32'h40] = 32'h11; bmem[32'h44] = 32'h22;
    bmem[32'h48] = 32'h33; bmem[32'h4C] = 32'h44;
    do_access(1'b1, 1'b0, 32'h40, 32'h0, "lw40_fill");
    do_access(1'b1, 1'b0, 32'h44, 32'h0, "lw44_hit");
    vectors++;
    if (mc_data[4][1] !== 32'h22) begin
      miscompares++;
      $display("FAIL model_line4_word1: got %h required 00000022", mc_data[4][1]);
    end
  endtask

  task automatic test_write_hit();
    do_access(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, "sw48_hit");
    do_access(1'b1, 1'b0, 32'h48, 32'h0, "lw48_hit");
  endtask

  task automatic test_dirty_evict();
    do_access(1'b1, 1'b0, 32'h448, 32'h0, "lw448_evict");
    vectors++;
    if (bmem[32'h48] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL writeback_0x48: got %h required deadbeef", bmem[32'h48]);
    end
  endtask

  task automatic test_store_miss();
    do_access(1'b0, 1'b1, 32'h800, 32'hCAFE_0800, "sw800_miss");
    do_access(1'b1, 1'b0, 32'hC00, 32'h0, "lwC00_evict800");
  endtask

  task automatic test_reset_mid_fill();
    int base;
    bit seen;
    bus_wait = 0;
    base = log_q.size();
    seen = 1'b0;
    cpu_addr = 32'h100; cpu_ren = 1'b1;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #2;
      if (log_q.size() == base + 2 && bus_ack) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_fill_second_ack: got %0d words required 2", log_q.size() - base);
    end
    rst = 1'b1; cpu_ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("rst_mid_fill_idle");
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (log_q.size() != base + 2) begin
      miscompares++;
      $display("FAIL rst_fill_abandon: got %0d words required 2", log_q.size() - base);
    end
    do_access(1'b1, 1'b0, 32'h100, 32'h0, "lw100_refetch");
    do_access(1'b1, 1'b0, 32'h44C, 32'h0, "lw44C_after_rst");
  endtask

  task automatic test_wait_states();
    int err0;
    err0 = stable_err;
    bus_wait = 3;
    do_access(1'b1, 1'b0, 32'h1230, 32'h0, "wait_clean_miss");
    do_access(1'b0, 1'b1, 32'h1234, 32'h5555_AAAA, "wait_sw_hit");
    do_access(1'b1, 1'b0, 32'h1630, 32'h0, "wait_dirty_miss");
    bus_wait = 0;
    vectors++;
    if (stable_err != err0) begin
      miscompares++;
      $display("FAIL wait_bus_stability: got %0d unstable cycles required 0", stable_err - err0);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op;
    spurious = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        vectors++;
        if (mem_stall !== 1'b0 || bus_cs !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_idle_%0d: got stall=%b cs=%b required 0 0", n, mem_stall, bus_cs);
        end
        @(posedge clk); #1;
      end
      bus_wait = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, a, $urandom, $sformatf("rand%0d", n));
    end
    spurious = 1'b0;
    bus_wait = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, 1'b1, 32'h2000 + 32'(i * 4), 32'hB0B0_0000 + 32'(i), $sformatf("b2b_sw%0d", i));
      do_access(1'b1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, $sformatf("b2b_lw%0d", i));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    test_reset();
    test_read_fill();
    test_write_hit();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid_fill();
    test_wait_states();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
